// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and data memory.
// Read misses fill a whole 4-word line; every store goes to memory as a single-word write.
module dcache_responder #(
    parameter int unsigned LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_readM,
    input  logic        d_writeM,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    output logic        m_readM,
    output logic        m_writeM,
    output logic [15:0] m_address,
    output logic [15:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ready,
    output logic [15:0] num_read_hit,
    output logic [15:0] num_read_miss
);

    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned TAGW = 14 - IDXW;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [63:0]       data_q [LINES];
    logic              just_filled_q;
    logic [15:0]       hit_cnt_q, miss_cnt_q;

    logic [IDXW-1:0]   idx;
    logic [TAGW-1:0]   tag;
    logic [5:0]        word_lsb;
    logic              hit;
    logic              count_hit, count_miss, fill_en, word_we;

    assign idx      = d_address[IDXW+1:2];
    assign tag      = d_address[15:IDXW+2];
    assign word_lsb = {d_address[1:0], 4'b0000};
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    assign num_read_hit  = hit_cnt_q;
    assign num_read_miss = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        d_ready    = 1'b0;
        d_rdata    = 16'h0000;
        m_readM    = 1'b0;
        m_writeM   = 1'b0;
        m_address  = 16'h0000;
        m_wdata    = 16'h0000;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        fill_en    = 1'b0;
        word_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A store wins over a load when both request lines are high.
                if (d_writeM) begin
                    state_d = StWrite;
                end else if (d_readM) begin
                    if (hit) begin
                        d_ready   = 1'b1;
                        d_rdata   = data_q[idx][word_lsb +: 16];
                        count_hit = !just_filled_q;
                    end else begin
                        state_d    = StFill;
                        count_miss = 1'b1;
                    end
                end
            end
            StFill: begin
                m_readM   = 1'b1;
                m_address = {d_address[15:2], 2'b00};
                if (m_ready) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrite: begin
                m_writeM  = 1'b1;
                m_address = d_address;
                m_wdata   = d_wdata;
                if (m_ready) begin
                    word_we = hit;
                    state_d = StWdone;
                end
            end
            StWdone: begin
                d_ready = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            valid_q       <= '0;
            just_filled_q <= 1'b0;
            hit_cnt_q     <= 16'h0000;
            miss_cnt_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
            if (state_q == StIdle) begin
                just_filled_q <= 1'b0;
            end else if (fill_en) begin
                just_filled_q <= 1'b1;
            end
            if (count_hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (count_miss && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    // Tags and data need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_en) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= m_rdata;
            end else if (word_we) begin
                data_q[idx][word_lsb +: 16] <= d_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus randomized traffic
// compared against a line-level cache model and a reference memory image.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_readM, d_writeM;
    logic [15:0] d_address, d_wdata, d_rdata;
    logic        d_ready;
    logic        m_readM, m_writeM;
    logic [15:0] m_address, m_wdata;
    logic [63:0] m_rdata;
    logic        m_ready;
    logic [15:0] num_read_hit, num_read_miss;

    always #5 clk = ~clk;

    dcache_responder #(.LINES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_readM      (d_readM),
        .d_writeM     (d_writeM),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .m_readM      (m_readM),
        .m_writeM     (m_writeM),
        .m_address    (m_address),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ready      (m_ready),
        .num_read_hit (num_read_hit),
        .num_read_miss(num_read_miss)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // dram is what the memory responder actually holds; ref_mem is what it should hold.
    logic [15:0] dram    [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] dram_rd(input logic [15:0] a);
        if (dram.exists(a)) return dram[a];
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    // Cache model: which memory line each index currently holds.
    bit          mvalid [4];
    logic [11:0] mtag   [4];
    int unsigned mhits, mmiss;

    function automatic bit model_hit(input logic [15:0] a);
        return mvalid[a[3:2]] && (mtag[a[3:2]] == a[15:4]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endtask

    // Memory responder: m_ready comes after lat+1 cycles of a held request.
    int          lat     = 0;
    int          mcount  = 0;
    bit          stray_en = 1'b0;
    logic [15:0] fill_seen, wr_addr_seen, wr_data_seen;

    initial begin
        m_ready = 1'b0;
        m_rdata = 64'h0;
        forever begin
            @(posedge clk);
            #2;
            m_ready = 1'b0;
            if (m_readM || m_writeM) begin
                mcount++;
                if (m_readM) fill_seen = m_address;
                if (m_writeM) begin
                    wr_addr_seen = m_address;
                    wr_data_seen = m_wdata;
                end
                if (mcount == lat + 1) begin
                    m_ready = 1'b1;
                    mcount  = 0;
                    if (m_readM) begin
                        m_rdata = {dram_rd(m_address + 16'd3), dram_rd(m_address + 16'd2),
                                   dram_rd(m_address + 16'd1), dram_rd(m_address)};
                    end else begin
                        dram[m_address] = m_wdata;
                    end
                end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                m_ready = 1'b1;
                m_rdata = {$urandom, $urandom};
            end
            if (reset) mcount = 0;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic check_counters(input string name);
        #2;
        check_eq({name, "_hits"}, 64'(num_read_hit), 64'(mhits));
        check_eq({name, "_miss"}, 64'(num_read_miss), 64'(mmiss));
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a);
        bit          exp_hit;
        int          exp_lat;
        int          c;
        logic [15:0] exp_data;
        exp_hit  = model_hit(a);
        exp_lat  = exp_hit ? 0 : lat + 2;
        exp_data = ref_rd(a);
        fill_seen = 16'hFFFF;
        d_readM   = 1'b1;
        d_writeM  = 1'b0;
        d_address = a;
        #2;
        check_eq("rd_hits_before", 64'(num_read_hit), 64'(mhits));
        check_eq("rd_miss_before", 64'(num_read_miss), 64'(mmiss));
        c = 0;
        while (!d_ready && c < 50) begin
            @(posedge clk);
            #3;
            c++;
        end
        check_eq("rd_latency", 64'(c), 64'(exp_lat));
        check_eq("rd_data", 64'(d_rdata), 64'(exp_data));
        if (exp_hit) begin
            if (mhits < 16'hFFFF) mhits++;
        end else begin
            check_eq("fill_addr", 64'(fill_seen), 64'({a[15:2], 2'b00}));
            if (mmiss < 16'hFFFF) mmiss++;
            mvalid[a[3:2]] = 1'b1;
            mtag[a[3:2]]   = a[15:4];
        end
        @(posedge clk);
        #1;
        d_readM = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] w, input bit with_read);
        int c;
        wr_addr_seen = 16'hFFFF;
        wr_data_seen = ~w;
        d_readM   = with_read;
        d_writeM  = 1'b1;
        d_address = a;
        d_wdata   = w;
        #2;
        c = 0;
        while (!d_ready && c < 50) begin
            @(posedge clk);
            #3;
            c++;
        end
        check_eq("wr_latency", 64'(c), 64'(lat + 2));
        check_eq("wr_addr", 64'(wr_addr_seen), 64'(a));
        check_eq("wr_data", 64'(wr_data_seen), 64'(w));
        ref_mem[a] = w;
        @(posedge clk);
        #1;
        d_readM  = 1'b0;
        d_writeM = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        reset     = 1'b1;
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        d_address = 16'h0042;
        d_wdata   = 16'h5555;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_m_readM", 64'(m_readM), 64'd0);
        check_eq("rst_m_writeM", 64'(m_writeM), 64'd0);
        check_eq("rst_m_address", 64'(m_address), 64'd0);
        check_eq("rst_m_wdata", 64'(m_wdata), 64'd0);
        check_eq("rst_d_ready", 64'(d_ready), 64'd0);
        check_eq("rst_d_rdata", 64'(d_rdata), 64'd0);
        check_eq("rst_hits", 64'(num_read_hit), 64'd0);
        check_eq("rst_miss", 64'(num_read_miss), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold miss then hit on the filled line.
        for (int i = 0; i < 4; i++) begin
            dram[16'h0040 + 16'(i)]    = 16'h1111 * 16'(i + 1);
            ref_mem[16'h0040 + 16'(i)] = 16'h1111 * 16'(i + 1);
        end
        lat = 3;
        do_read(16'h0042);
        do_read(16'h0043);
        check_counters("cold");

        // Write hit must update the cached word.
        lat = 2;
        do_write(16'h0041, 16'hBEEF, 1'b0);
        do_read(16'h0041);

        // Write miss must not allocate.
        lat = 1;
        do_write(16'h0100, 16'h1234, 1'b0);
        do_read(16'h0100);

        // Same index, different tag evicts.
        lat = 0;
        do_read(16'h0000);
        do_read(16'h0010);
        do_read(16'h0000);
        check_counters("evict");

        // Reset together with m_ready in the second fill cycle discards the fill.
        lat = 1;
        d_readM   = 1'b1;
        d_address = 16'h0F84;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        d_readM = 1'b0;
        model_reset();
        #2;
        check_eq("rstfill_m_readM", 64'(m_readM), 64'd0);
        check_eq("rstfill_d_ready", 64'(d_ready), 64'd0);
        check_counters("rstfill");
        lat = 2;
        do_read(16'h0F84);

        // Randomized traffic with stray m_ready pulses while idle.
        stray_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a   = {10'b0, 2'($urandom_range(0, 2)), 4'($urandom)};
            lat = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
                do_write(a, 16'($urandom), ($urandom_range(0, 7) == 0));
            end else begin
                do_read(a);
            end
            repeat ($urandom_range(0, 2)) begin
                #2;
                check_eq("idle_d_ready", 64'(d_ready), 64'd0);
                @(posedge clk);
                #1;
            end
        end
        stray_en = 1'b0;
        check_counters("random");

        // Held read hit drives the hit counter into saturation.
        lat = 0;
        do_read(16'h0024);
        d_readM   = 1'b1;
        d_address = 16'h0024;
        repeat (66000) @(posedge clk);
        #2;
        check_eq("sat_d_ready", 64'(d_ready), 64'd1);
        check_eq("sat_d_rdata", 64'(d_rdata), 64'(ref_rd(16'h0024)));
        #1;
        d_readM = 1'b0;
        mhits   = 16'hFFFF;
        check_counters("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
